instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly upstream of the instruction decoder. Holds the program counter
//  and reads instruction words over a req/ack memory port. Ops 2/5/7 (set/addv/subv)
//  carry a second immediate word, which this block also fetches.
//  Presents {op, operand, imm} to the decoder with a valid/ready handshake, takes jump
//  redirects, and stops fetching once a halt (op 1) has been handed over.
// PARAMETERS
//  w          8   data/instruction word width
//  op_w       3   opcode width; opcode = word[w-1:w-op_w]
//  addr_w     8   program counter / memory address width
//  reset_addr 0   PC value after reset
// PORTS
//  clock      in   1          rising-edge clock
//  reset_n    in   1          synchronous reset, active low
//  mem_req    out  1          memory read request
//  mem_addr   out  addr_w     read address; stable while mem_req=1 and mem_ack=0
//  mem_ack    in   1          read complete; mem_data valid in this cycle
//  mem_data   in   w          read data
//  op         out  op_w       opcode to decoder
//  operand    out  w-op_w     low bits of first word (register fields)
//  imm        out  w          immediate word; 0 for single-word ops
//  out_valid  out  1          op/operand/imm valid
//  out_ready  in   1          decoder accepts; transfer = out_valid & out_ready
//  jump_en    in   1          redirect PC
//  jump_addr  in   addr_w     redirect target
//  halted     out  1          halt consumed, fetch stopped
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=FETCH_OP, pc=reset_addr, all outputs 0.
//  FSM states: FETCH_OP, FETCH_IMM, PRESENT, HALTED.
//  FETCH_OP: mem_req=1, mem_addr=pc.
//    On ack: latch op/operand, pc<=pc+1.
//    If op in {2,5,7}: go to FETCH_IMM. Otherwise imm<=0 and go to PRESENT.
//  FETCH_IMM: mem_req=1, mem_addr=pc. On ack: imm<=mem_data, pc<=pc+1, go to PRESENT.
//  PRESENT: out_valid=1, mem_req=0. Outputs hold until the transfer.
//    On transfer: go to HALTED if op==1, else to FETCH_OP.
//  HALTED: mem_req=0, out_valid=0, halted=1. Only reset exits; jump_en is ignored.
//  Latency with zero-wait memory (ack in the request cycle):
//    single-word op: out_valid 1 cycle after the request.
//    two-word op: 2 cycles.
//    Next request issues the cycle after the transfer.
//  pc increments modulo 2^addr_w (wraps from all-ones to 0).
//  Op 0 and every other opcode are fetched and presented unchanged; no checking here.
//  jump_en (any state except HALTED):
//    pc<=jump_addr; state goes to FETCH_OP, with one exception:
//    a request already outstanding (mem_req=1, no ack yet) stays asserted, with its
//    address unchanged, until ack. That returned data is discarded and the fetch then
//    restarts from jump_addr.
//    In PRESENT: the held instruction is dropped (out_valid=0 next cycle), unless
//    out_ready=1 in the same cycle, in which case the transfer completes, then redirect.
//    jump_en in the same cycle as mem_ack: the ack'd data is discarded, pc<=jump_addr.
//  Reset mid-fetch: request dropped immediately; memory must tolerate an abandoned req.
// TESTING
//  1. Reset, mem[0]=8'h80 (op 4), zero-wait ack, out_ready=1:
//     mem_addr=0, then op=4, operand=0, imm=0, out_valid for 1 cycle; next mem_addr=1.
//  2. mem[0]=8'hA3 (op 5), mem[1]=8'h2A:
//     two requests (addr 0, 1), then op=5, operand=5'h03, imm=8'h2A; next fetch addr 2.
//  3. out_ready=0 for 4 cycles while presenting:
//     out_valid and op/operand/imm stable, mem_req=0; transfer on the cycle ready rises.
//  4. mem_ack delayed 3 cycles, jump_en=1 to 8'h40 in wait cycle 1:
//     mem_addr held until ack, data dropped, next request mem_addr=8'h40.
//  5. pc=8'hFF, single-word op: next fetch at 8'h00.
//  6. mem[0]=8'h20 (halt) accepted: halted=1, mem_req stays 0 for 20 cycles despite
//     jump_en pulses; reset_n=0 then restarts at reset_addr.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads one or two words per instruction over a
// req/ack port and hands {op, operand, imm} to the decoder on valid/ready.
module instruction_fetch #(
   parameter int unsigned        w          = 8,
   parameter int unsigned        op_w       = 3,
   parameter int unsigned        addr_w     = 8,
   parameter logic [addr_w-1:0]  reset_addr = '0
) (
   input  logic                clock,
   input  logic                reset_n,
   output logic                mem_req,
   output logic [addr_w-1:0]   mem_addr,
   input  logic                mem_ack,
   input  logic [w-1:0]        mem_data,
   output logic [op_w-1:0]     op,
   output logic [w-op_w-1:0]   operand,
   output logic [w-1:0]        imm,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                jump_en,
   input  logic [addr_w-1:0]   jump_addr,
   output logic                halted
);

   typedef enum logic [1:0] {
      FETCH_OP,
      FETCH_IMM,
      PRESENT,
      HALTED
   } state_t;

   localparam logic [op_w-1:0] OP_HALT = op_w'(1);
   localparam logic [op_w-1:0] OP_SET  = op_w'(2);
   localparam logic [op_w-1:0] OP_ADDV = op_w'(5);
   localparam logic [op_w-1:0] OP_SUBV = op_w'(7);

   state_t              state_q, state_d;
   logic [addr_w-1:0]   pc_q, pc_d;
   logic [addr_w-1:0]   hold_q, hold_d;
   logic                drop_q, drop_d;
   logic [op_w-1:0]     op_q, op_d;
   logic [w-op_w-1:0]   operand_q, operand_d;
   logic [w-1:0]        imm_q, imm_d;
   logic                req_c;
   logic [op_w-1:0]     rd_op;
   logic                two_word;

   assign rd_op    = mem_data[w-1 -: op_w];
   assign two_word = (rd_op == OP_SET) || (rd_op == OP_ADDV) ||
                     (rd_op == OP_SUBV);

   // Reset is synchronous, but an abandoned request must drop at once.
   assign mem_req = reset_n & req_c;
   assign op      = op_q;
   assign operand = operand_q;
   assign imm     = imm_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= FETCH_OP;
         pc_q      <= reset_addr;
         hold_q    <= '0;
         drop_q    <= 1'b0;
         op_q      <= '0;
         operand_q <= '0;
         imm_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         hold_q    <= hold_d;
         drop_q    <= drop_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         imm_q     <= imm_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      hold_d    = hold_q;
      drop_d    = drop_q;
      op_d      = op_q;
      operand_d = operand_q;
      imm_d     = imm_q;
      req_c     = 1'b0;
      mem_addr  = pc_q;
      out_valid = 1'b0;
      halted    = 1'b0;

      unique case (state_q)
         FETCH_OP, FETCH_IMM: begin
            req_c = 1'b1;
            if (drop_q) begin
               // Redirected while waiting: keep the old address until ack.
               mem_addr = hold_q;
               if (jump_en) begin
                  pc_d = jump_addr;
               end
               if (mem_ack) begin
                  drop_d  = 1'b0;
                  state_d = FETCH_OP;
               end
            end else if (jump_en) begin
               pc_d    = jump_addr;
               state_d = FETCH_OP;
               if (!mem_ack) begin
                  drop_d = 1'b1;
                  hold_d = pc_q;
               end
            end else if (mem_ack) begin
               pc_d = pc_q + addr_w'(1);
               if (state_q == FETCH_IMM) begin
                  imm_d   = mem_data;
                  state_d = PRESENT;
               end else begin
                  op_d      = rd_op;
                  operand_d = mem_data[w-op_w-1:0];
                  if (two_word) begin
                     state_d = FETCH_IMM;
                  end else begin
                     imm_d   = '0;
                     state_d = PRESENT;
                  end
               end
            end
         end

         PRESENT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (op_q == OP_HALT) begin
                  state_d = HALTED;
               end else begin
                  state_d = FETCH_OP;
                  if (jump_en) begin
                     pc_d = jump_addr;
                  end
               end
            end else if (jump_en) begin
               pc_d    = jump_addr;
               state_d = FETCH_OP;
            end
         end

         HALTED: begin
            halted = 1'b1;
         end

         default: begin
            state_d = FETCH_OP;
         end
      endcase
   end

endmodule
